// File: rtl/cacheline_adaptor.sv
// Line-to-burst adaptor: turns one cache-line read or write into NUM_BURSTS
// memory beats (least-significant beat first) and returns a one-cycle line response.
module cacheline_adaptor #(
    parameter int unsigned BURST_W    = 64,
    parameter int unsigned NUM_BURSTS = 4,
    parameter int unsigned OFFSET_W   = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BURST_W*NUM_BURSTS-1:0] line_i,
    output logic [BURST_W*NUM_BURSTS-1:0] line_o,
    input  logic [31:0]                   address_i,
    input  logic                          read_i,
    input  logic                          write_i,
    output logic                          resp_o,
    input  logic [BURST_W-1:0]            burst_i,
    output logic [BURST_W-1:0]            burst_o,
    output logic [31:0]                   address_o,
    output logic                          read_o,
    output logic                          write_o,
    input  logic                          resp_i
);

    localparam int unsigned LINE_W = BURST_W * NUM_BURSTS;
    localparam int unsigned CNT_W  = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BURSTS - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]  beat, beat_next;
    logic [31:0]       addr_q;
    logic [LINE_W-1:0] wline_q;
    logic [LINE_W-1:0] rline_q;
    logic              take_rd, take_wr, take_beat;
    logic [31:0]       line_addr;

    assign line_addr = {addr_q[31:OFFSET_W], {OFFSET_W{1'b0}}};
    assign line_o    = rline_q;

    always_comb begin
        state_next = state;
        beat_next  = beat;
        take_rd    = 1'b0;
        take_wr    = 1'b0;
        take_beat  = 1'b0;
        read_o     = 1'b0;
        write_o    = 1'b0;
        resp_o     = 1'b0;
        address_o  = '0;
        burst_o    = '0;

        unique case (state)
            IDLE: begin
                // write has priority when both requests arrive together
                if (write_i) begin
                    take_wr    = 1'b1;
                    state_next = WRITE;
                end else if (read_i) begin
                    take_rd    = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                read_o    = 1'b1;
                address_o = line_addr;
                if (resp_i) begin
                    take_beat = 1'b1;
                    if (beat == LAST_BEAT) begin
                        beat_next  = '0;
                        state_next = DONE;
                    end else begin
                        beat_next = beat + CNT_W'(1);
                    end
                end
            end
            WRITE: begin
                write_o   = 1'b1;
                address_o = line_addr;
                burst_o   = wline_q[beat*BURST_W +: BURST_W];
                if (resp_i) begin
                    if (beat == LAST_BEAT) begin
                        beat_next  = '0;
                        state_next = DONE;
                    end else begin
                        beat_next = beat + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                resp_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            beat    <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            state <= state_next;
            beat  <= beat_next;
            if (take_rd || take_wr) begin
                addr_q <= address_i;
            end
            if (take_wr) begin
                wline_q <= line_i;
            end
            if (take_beat) begin
                rline_q[beat*BURST_W +: BURST_W] <= burst_i;
            end
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: a driver issues line transactions, a memory
// responder serves/checks beats, and a monitor checks each line response.
module tb_cacheline_adaptor;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] line;
    } txn_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i, write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o, write_o;
    logic         resp_i;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_beat_cyc = -10;
    int   mem_beat = 0;
    logic [255:0] last_rd_line = '0;

    txn_t exp_q[$];
    txn_t mem_q[$];
    bit   gap_q[$];

    cacheline_adaptor #(
        .BURST_W   (64),
        .NUM_BURSTS(4),
        .OFFSET_W  (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .line_i   (line_i),
        .line_o   (line_o),
        .address_i(address_i),
        .read_i   (read_i),
        .write_i  (write_i),
        .resp_o   (resp_o),
        .burst_i  (burst_i),
        .burst_o  (burst_o),
        .address_o(address_o),
        .read_o   (read_o),
        .write_o  (write_o),
        .resp_i   (resp_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Memory responder: serves read beats, checks write beats and request outputs.
    initial begin
        txn_t         t;
        logic [255:0] sh;
        bit           go;
        resp_i  = 1'b0;
        burst_i = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (mem_beat != 0 && mem_q.size() > 0) void'(mem_q.pop_front());
                mem_beat = 0;
                resp_i   = 1'($urandom_range(0, 1));
                burst_i  = {$urandom, $urandom};
                continue;
            end
            if (read_o || write_o) begin
                if (mem_q.size() == 0) begin
                    chk("unexpected_request", {254'd0, read_o, write_o}, 256'd0);
                    resp_i = 1'b0;
                end else begin
                    t = mem_q[0];
                    chk("request_kind", {254'd0, read_o, write_o}, {254'd0, !t.wr, t.wr});
                    chk("address_o", 256'(address_o), 256'(t.addr & 32'hFFFF_FFE0));
                    if (gap_q.size() > 0) go = gap_q.pop_front();
                    else go = ($urandom_range(0, 3) != 0);
                    sh = t.line >> (64 * mem_beat);
                    if (t.wr) begin
                        burst_i = {$urandom, $urandom};
                        if (go) chk($sformatf("burst_o_beat%0d", mem_beat), 256'(burst_o), 256'(sh[63:0]));
                    end else begin
                        chk("burst_o_zero_in_read", 256'(burst_o), 256'd0);
                        burst_i = go ? sh[63:0] : {$urandom, $urandom};
                    end
                    resp_i = go;
                    if (go) begin
                        mem_beat++;
                        if (mem_beat == 4) begin
                            void'(mem_q.pop_front());
                            mem_beat      = 0;
                            last_beat_cyc = cyc;
                        end
                    end
                end
            end else begin
                chk("idle_outputs", {address_o, burst_o, 32'(mem_beat)}, 256'd0);
                resp_i  = ($urandom_range(0, 3) == 0);
                burst_i = {$urandom, $urandom};
            end
        end
    end

    // Line-response monitor.
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_rd_line = '0;
                continue;
            end
            if (resp_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp_o", 256'd1, 256'd0);
                end else begin
                    t = exp_q.pop_front();
                    chk("resp_o_timing", 256'(cyc - last_beat_cyc), 256'd1);
                    if (t.wr) begin
                        chk("line_o_after_write", line_o, last_rd_line);
                    end else begin
                        chk("line_o_after_read", line_o, t.line);
                        last_rd_line = t.line;
                    end
                end
            end
        end
    end

    // op: 0 read, 1 write, 2 both requests together
    task automatic run_txn(input int op, input logic [31:0] a, input logic [255:0] wl,
                           input logic [255:0] rd);
        txn_t t;
        int   n;
        @(posedge clk); #2;
        t.wr   = (op != 0);
        t.addr = a;
        t.line = t.wr ? wl : rd;
        exp_q.push_back(t);
        mem_q.push_back(t);
        address_i = a;
        line_i    = wl;
        read_i    = (op != 1);
        write_i   = (op != 0);
        @(posedge clk); #2;
        address_i = $urandom;
        line_i    = rand256();
        n = 0;
        while (!resp_o && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        read_i  = 1'b0;
        write_i = 1'b0;
        if (n >= 200) begin
            chk("resp_o_timeout", 256'd0, 256'd1);
            finish_run();
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_read_o"}, 256'(read_o), 256'd0);
        chk({tag, "_write_o"}, 256'(write_o), 256'd0);
        chk({tag, "_resp_o"}, 256'(resp_o), 256'd0);
        chk({tag, "_address_o"}, 256'(address_o), 256'd0);
        chk({tag, "_burst_o"}, 256'(burst_o), 256'd0);
        chk({tag, "_line_o"}, line_o, 256'd0);
    endtask

    initial begin
        txn_t t;
        int   n;
        int   op;
        rst       = 1'b1;
        read_i    = 1'b0;
        write_i   = 1'b0;
        address_i = '0;
        line_i    = '0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        rst = 1'b0;

        // Directed read with back-to-back beats
        gap_q = {1, 1, 1, 1};
        run_txn(0, 32'h0000_1234, '0,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        // Directed write with back-to-back beats
        gap_q = {1, 1, 1, 1};
        run_txn(1, 32'h8000_003F, {64'hD, 64'hC, 64'hB, 64'hA}, '0);
        // Read with beat gaps
        gap_q = {1, 0, 0, 1, 1, 0, 1};
        run_txn(0, 32'h0000_0300, '0, rand256());
        // Simultaneous read and write requests
        run_txn(2, 32'h0000_0480, rand256(), '0);

        // Reset during a read after two beats
        @(posedge clk); #2;
        t.wr   = 1'b0;
        t.addr = 32'h0000_0040;
        t.line = rand256();
        exp_q.push_back(t);
        mem_q.push_back(t);
        address_i = t.addr;
        read_i    = 1'b1;
        n = 0;
        while (mem_beat < 2 && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 200) begin
            chk("reset_test_timeout", 256'd0, 256'd1);
            finish_run();
        end
        rst    = 1'b1;
        read_i = 1'b0;
        void'(exp_q.pop_back());
        @(posedge clk); #2;
        check_all_zero("midreset");
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("postreset");
        run_txn(0, 32'h0000_0040, '0, rand256());

        // Back-to-back write then read
        run_txn(1, 32'h0000_0100, rand256(), '0);
        run_txn(0, 32'h0000_0200, '0, rand256());

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 9);
            op = (op < 4) ? 0 : (op < 8) ? 1 : 2;
            run_txn(op, $urandom, rand256(), rand256());
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (10) @(posedge clk);
        #2;
        chk("exp_q_drained", 256'(exp_q.size()), 256'd0);
        chk("mem_q_drained", 256'(mem_q.size()), 256'd0);
        finish_run();
    end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits directly downstream of the cache arbiter, between the arbiter's 256-bit line port and the 64-bit burst main-memory port.
- Converts one line read or write into NUM_BURSTS sequential bursts, least-significant beat first.
- Returns a single-cycle line-level response to the arbiter.

Parameters:
BURST_W, 64, width in bits of one memory beat
NUM_BURSTS, 4, beats per cache line; LINE_W = BURST_W*NUM_BURSTS (256)
OFFSET_W, 5, byte-offset bits cleared on address_o (log2 of LINE_W/8)

Ports:
clk  in  1  clock
rst  in  1  reset
line_i  in  LINE_W  write line from arbiter (cline_wdata)
line_o  out  LINE_W  read line to arbiter (cline_rdata)
address_i  in  32  line address from arbiter
read_i  in  1  line read request
write_i  in  1  line write request
resp_o  out  1  line transfer complete, one-cycle pulse
burst_i  in  BURST_W  read beat from memory
burst_o  out  BURST_W  write beat to memory
address_o  out  32  memory address, low OFFSET_W bits forced 0
read_o  out  1  memory read request
write_o  out  1  memory write request
resp_i  in  1  memory beat accepted/valid

Behaviour:
- Reset: rst is synchronous, active-high, on clk. Reset forces:
  - state=IDLE, beat counter=0;
  - read_o, write_o, resp_o = 0; address_o = 0; burst_o = 0; line_o = 0.
- States:
  - IDLE: no memory request driven. Samples read_i/write_i each cycle.
    - On write_i, latch address_i and line_i, then go to WRITE. write_i wins if both requests are high.
    - Else on read_i, latch address_i, then go to READ.
    - resp_i is ignored in IDLE.
  - READ:
    - read_o=1; address_o = latched address with [OFFSET_W-1:0]=0.
    - On each cycle with resp_i=1, capture burst_i into line buffer slice [k*BURST_W +: BURST_W] and increment k.
    - When resp_i=1 and k=NUM_BURSTS-1, clear k and go to DONE.
  - WRITE:
    - write_o=1; same address_o; burst_o = latched line slice k.
    - On each resp_i=1, increment k.
    - When resp_i=1 and k=NUM_BURSTS-1, clear k and go to DONE.
  - DONE:
    - resp_o=1 for exactly one cycle; read_o and write_o = 0.
    - Go to IDLE unconditionally.
- Beat timing:
  - resp_i beats need not be consecutive. The counter advances only on resp_i=1, and read_o/write_o stay high through gaps.
  - read_o/write_o drop the cycle after the final beat is accepted.
- Latency:
  - Request seen at edge E0 → read_o/write_o high from cycle E0+1.
  - Final beat at cycle Ef → resp_o high at Ef+1 → IDLE at Ef+2.
  - Minimum total for back-to-back beats: 1 + 4 + 1 = 6 cycles from request to resp_o.
- line_o: driven from the internal line buffer. Valid when resp_o=1 after a READ and held until the next READ overwrites beat 0. A WRITE never alters line_o.
- Latching: address_i and line_i changes after the IDLE sample have no effect on the transfer in flight.
- DONE→IDLE: request inputs are not sampled in DONE. A request still high in the IDLE cycle after DONE starts a new transfer. The arbiter drops its request after resp_o, so no duplicate occurs.
- Counter: width clog2(NUM_BURSTS). It wraps to 0 only via the explicit clear, never by overflow.
- Reset mid-transfer:
  - The transfer is abandoned: IDLE, k=0, all outputs to their reset values.
  - No resp_o is generated.
  - Late resp_i beats arriving in IDLE are ignored.
- burst_o is 0 outside WRITE. address_o is 0 in IDLE and DONE.

Test Plan:
- Read, back-to-back beats:
  - Stimulus: address_i=0x0000_1234, read_i=1; memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive resp_i cycles.
  - Required: address_o=0x0000_1220; read_o high exactly 4 cycles; resp_o pulses 1 cycle; line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write, back-to-back beats:
  - Stimulus: line_i = {64'hD, 64'hC, 64'hB, 64'hA}, address_i=0x8000_003F, write_i=1.
  - Required: address_o=0x8000_0020; burst_o = A, B, C, D on the successive resp_i cycles; resp_o one pulse; line_o unchanged.
- Read with beat gaps:
  - Stimulus: resp_i pattern 1,0,0,1,1,0,1.
  - Required: read_o stays high throughout; 4 beats captured in order; resp_o exactly 1 cycle after the last resp_i.
- Simultaneous read_i and write_i:
  - Required: WRITE is taken; write_o=1 and read_o=0 for the whole transfer.
- Reset during READ:
  - Stimulus: rst after beat 2, then 2 stray resp_i pulses.
  - Required: all outputs 0; no resp_o; next read of 0x40 completes normally with fresh data in all 4 beats.
- Back-to-back transactions:
  - Stimulus: a write to 0x100, then a read to 0x200 asserted in the cycle after resp_o.
  - Required: exactly two resp_o pulses; no duplicate transfer; read address_o=0x200.
